ntt_bpe: RTL and testbench

Butterfly processing element: the responder end of the kernel_FFT BPEn_* interface (ain/bin/coef in, aout/bout out, i_vld/i_rdy, o_vld/o_rdy).
- Computes 4 independent modular NTT butterflies per beat, one per 32-bit lane of the 128-bit bus.
- Fixed 3-stage pipeline with full backpressure.
- Five instances sit beside the kernel, one per BPE slot.

---
 rtl/bpe_pkg.sv | 29 ++
 rtl/bpe_chk.sv | 27 ++
 rtl/bpe_modmul.sv | 55 +++++
 rtl/ntt_bpe.sv | 129 ++++++++++++
 tb/tb_ntt_bpe.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bpe_pkg.sv
// Shared constants and modular helpers for the ntt_bpe butterfly element.
// Optional Gentleman-Sande mode in ntt_bpe is enabled by the BPE_GS_EN macro.
package bpe_pkg;

  localparam int LANE_W = 32;
  localparam int N_LANE = 4;
  localparam int QW     = 23;
  localparam int MW     = 24;

  localparam logic [QW-1:0] Q = 23'd8380417;

  // floor(2^(2*QW)/Q); MW bits is enough because Q is just below 2^QW
  localparam logic [MW-1:0] BARRETT_M = MW'((64'd1 << (2*QW)) / {41'd0, Q});

  // (a + b) mod Q for a, b < Q
  function automatic logic [QW-1:0] modadd(input logic [QW-1:0] a, input logic [QW-1:0] b);
    logic [QW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= {1'b0, Q}) ? QW'(s - {1'b0, Q}) : QW'(s);
  endfunction

  // (a - b) mod Q for a, b < Q; the borrow bit flags a negative difference
  function automatic logic [QW-1:0] modsub(input logic [QW-1:0] a, input logic [QW-1:0] b);
    logic [QW:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[QW] ? QW'(d + {1'b0, Q}) : QW'(d);
  endfunction

endpackage

// File: rtl/bpe_chk.sv
// Simulation checker for ntt_bpe: flags any accepted operand lane that is not reduced below Q.
module bpe_chk
  import bpe_pkg::*;
(
  input logic                 clk,
  input logic                 rstn,
  input logic                 acc,
  input logic [N_LANE*QW-1:0] a_pk,
  input logic [N_LANE*QW-1:0] b_pk,
  input logic [N_LANE*QW-1:0] c_pk
);

  function automatic logic in_range(input logic [N_LANE*QW-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < N_LANE; i++) begin
      if (v[QW*i +: QW] >= Q) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

  a_operand_range: assert property (@(posedge clk) disable iff (!rstn)
    acc |-> (in_range(a_pk) && in_range(b_pk) && in_range(c_pk)));

endmodule

// File: rtl/bpe_modmul.sv
// One lane of (a*b) mod Q: S1 registers the raw product, S2 registers the Barrett-reduced result.
module bpe_modmul
  import bpe_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic [QW-1:0] a,
  input  logic [QW-1:0] b,
  output logic [QW-1:0] r
);

  logic [2*QW-1:0]    prod_r;
  logic [2*QW+MW-1:0] bm_s;
  logic [QW-1:0]      q_s;
  logic [QW:0]        qq_s;
  logic [QW:0]        rem_s;
  logic [QW-1:0]      red_s;
  logic [QW-1:0]      r_r;

  // S1 product register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prod_r <= {(2*QW){1'b0}};
    end else if (en) begin
      prod_r <= {{QW{1'b0}}, a} * {{QW{1'b0}}, b};
    end
  end

  // Barrett reduction; the quotient estimate is at most one short, so r < 2Q before the fix-up.
  // Only the low QW+1 bits of x - q*Q are kept since the true remainder fits there.
  always_comb begin
    bm_s  = {{MW{1'b0}}, prod_r} * {{(2*QW){1'b0}}, BARRETT_M};
    q_s   = QW'(bm_s >> (2*QW));
    qq_s  = {1'b0, q_s} * {1'b0, Q};
    rem_s = prod_r[QW:0] - qq_s;
    if (rem_s >= {1'b0, Q}) begin
      red_s = QW'(rem_s - {1'b0, Q});
    end else begin
      red_s = rem_s[QW-1:0];
    end
  end

  // S2 reduced-result register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_r <= {QW{1'b0}};
    end else if (en) begin
      r_r <= red_s;
    end
  end

  assign r = r_r;

endmodule

// File: rtl/ntt_bpe.sv
// Four-lane NTT butterfly element, 3-stage pipeline with a single global stall enable.
// Define BPE_GS_EN to add the i_gs port selecting the Gentleman-Sande butterfly per beat.
module ntt_bpe
  import bpe_pkg::*;
#(
  parameter int pDATA_WIDTH = N_LANE * LANE_W
)
(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [pDATA_WIDTH-1:0] ain,
  input  logic [pDATA_WIDTH-1:0] bin,
  input  logic [pDATA_WIDTH-1:0] coef,
  input  logic                   i_vld,
`ifdef BPE_GS_EN
  input  logic                   i_gs,
`endif
  output logic                   i_rdy,
  output logic [pDATA_WIDTH-1:0] aout,
  output logic [pDATA_WIDTH-1:0] bout,
  output logic                   o_vld,
  input  logic                   o_rdy
);

  logic en_s;
  logic gs_in_s;
  logic v1_r, v2_r, v3_r;
  logic gs1_r, gs2_r;

  logic [QW-1:0] a_s    [N_LANE];
  logic [QW-1:0] b_s    [N_LANE];
  logic [QW-1:0] c_s    [N_LANE];
  logic [QW-1:0] mb_s   [N_LANE];
  logic [QW-1:0] a1in_s [N_LANE];
  logic [QW-1:0] a1_r   [N_LANE];
  logic [QW-1:0] a2_r   [N_LANE];
  logic [QW-1:0] t2_s   [N_LANE];

  logic [N_LANE*QW-1:0] a_pk_s, b_pk_s, c_pk_s;
  logic [3*N_LANE*(LANE_W-QW)-1:0] unused_hi_s;

  logic [pDATA_WIDTH-1:0] aout_r, bout_r;

`ifdef BPE_GS_EN
  assign gs_in_s = i_gs;
`else
  assign gs_in_s = 1'b0;
`endif

  assign en_s  = ~v3_r | o_rdy;
  assign i_rdy = en_s;
  assign o_vld = v3_r;
  assign aout  = aout_r;
  assign bout  = bout_r;

  for (genvar i = 0; i < N_LANE; i++) begin : g_lane
    assign a_s[i] = ain[LANE_W*i +: QW];
    assign b_s[i] = bin[LANE_W*i +: QW];
    assign c_s[i] = coef[LANE_W*i +: QW];
    assign a_pk_s[QW*i +: QW] = a_s[i];
    assign b_pk_s[QW*i +: QW] = b_s[i];
    assign c_pk_s[QW*i +: QW] = c_s[i];
    assign unused_hi_s[3*(LANE_W-QW)*i +: 3*(LANE_W-QW)] =
      {ain[LANE_W*i+QW +: LANE_W-QW], bin[LANE_W*i+QW +: LANE_W-QW], coef[LANE_W*i+QW +: LANE_W-QW]};

    bpe_modmul u_modmul (
      .clk  (clk),
      .rstn (rstn),
      .en   (en_s),
      .a    (c_s[i]),
      .b    (mb_s[i]),
      .r    (t2_s[i])
    );
  end

  // S1 operand select: GS folds the add/sub ahead of the multiplier
  always_comb begin
    for (int i = 0; i < N_LANE; i++) begin
      if (gs_in_s) begin
        mb_s[i]   = modsub(a_s[i], b_s[i]);
        a1in_s[i] = modadd(a_s[i], b_s[i]);
      end else begin
        mb_s[i]   = b_s[i];
        a1in_s[i] = a_s[i];
      end
    end
  end

  // Valid chain, mode bits, top-operand delay line and S3 output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_r   <= 1'b0;
      v2_r   <= 1'b0;
      v3_r   <= 1'b0;
      gs1_r  <= 1'b0;
      gs2_r  <= 1'b0;
      aout_r <= {pDATA_WIDTH{1'b0}};
      bout_r <= {pDATA_WIDTH{1'b0}};
      for (int i = 0; i < N_LANE; i++) begin
        a1_r[i] <= {QW{1'b0}};
        a2_r[i] <= {QW{1'b0}};
      end
    end else if (en_s) begin
      v1_r  <= i_vld;
      v2_r  <= v1_r;
      v3_r  <= v2_r;
      gs1_r <= gs_in_s;
      gs2_r <= gs1_r;
      for (int i = 0; i < N_LANE; i++) begin
        a1_r[i] <= a1in_s[i];
        a2_r[i] <= a1_r[i];
        aout_r[LANE_W*i +: LANE_W] <=
          {{(LANE_W-QW){1'b0}}, (gs2_r ? a2_r[i] : modadd(a2_r[i], t2_s[i]))};
        bout_r[LANE_W*i +: LANE_W] <=
          {{(LANE_W-QW){1'b0}}, (gs2_r ? t2_s[i] : modsub(a2_r[i], t2_s[i]))};
      end
    end
  end

  bpe_chk u_chk (
    .clk  (clk),
    .rstn (rstn),
    .acc  (i_vld & en_s),
    .a_pk (a_pk_s),
    .b_pk (b_pk_s),
    .c_pk (c_pk_s)
  );

endmodule

// File: tb/tb_ntt_bpe.sv
// Directed and scoreboard bench for ntt_bpe; covers the BPE_GS_EN build when that macro is defined.
module tb_ntt_bpe;

  localparam int unsigned QV = 32'd8380417;
  localparam longint unsigned QL = 64'd8380417;

  logic         clk;
  logic         rstn;
  logic [127:0] ain, bin, coef;
  logic         i_vld;
  logic         i_gs;
  logic         i_rdy;
  logic [127:0] aout, bout;
  logic         o_vld;
  logic         o_rdy;

  int n_checks;
  int n_errors;
  int n_out;
  logic         hold_chk;
  logic [127:0] held_a, held_b;
  logic [127:0] exp_a_q[$];
  logic [127:0] exp_b_q[$];

  ntt_bpe dut (
    .clk   (clk),
    .rstn  (rstn),
    .ain   (ain),
    .bin   (bin),
    .coef  (coef),
    .i_vld (i_vld),
`ifdef BPE_GS_EN
    .i_gs  (i_gs),
`endif
    .i_rdy (i_rdy),
    .aout  (aout),
    .bout  (bout),
    .o_vld (o_vld),
    .o_rdy (o_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pk(input logic [31:0] l3, input logic [31:0] l2,
                                      input logic [31:0] l1, input logic [31:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  // Reference butterfly using plain % arithmetic; want_b selects the bottom output
  function automatic logic [127:0] model(input logic [127:0] a, input logic [127:0] b,
                                         input logic [127:0] c, input logic gs, input logic want_b);
    logic [127:0] r;
    longint unsigned av, bv, cv, t, ra, rb;
    r = 128'd0;
    for (int i = 0; i < 4; i++) begin
      av = 64'(a[32*i +: 23]);
      bv = 64'(b[32*i +: 23]);
      cv = 64'(c[32*i +: 23]);
      if (gs) begin
        ra = (av + bv) % QL;
        rb = (((av + QL - bv) % QL) * cv) % QL;
      end else begin
        t  = (cv * bv) % QL;
        ra = (av + t) % QL;
        rb = (av + QL - t) % QL;
      end
      r[32*i +: 32] = 32'(want_b ? rb : ra);
    end
    return r;
  endfunction

  function automatic logic [31:0] rnd_lane();
    return {9'($urandom_range(0, 511)), 23'($urandom_range(0, QV - 1))};
  endfunction

  function automatic logic [127:0] rnd128();
    return {rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()};
  endfunction

  // One isolated beat: expect o_vld on the third edge counting the accept edge
  task automatic beat(input string tag, input logic gs, input logic [127:0] a, input logic [127:0] b,
                      input logic [127:0] c, input logic [127:0] ea, input logic [127:0] eb);
    int k;
    @(posedge clk); #1;
    ain = a; bin = b; coef = c; i_gs = gs; i_vld = 1'b1; o_rdy = 1'b1;
    k = 0;
    do begin
      @(posedge clk); #1;
      i_vld = 1'b0;
      k++;
    end while (!o_vld && k < 10);
    chk({tag, "_lat"}, 128'(k), 128'(3));
    chk({tag, "_aout"}, aout, ea);
    chk({tag, "_bout"}, bout, eb);
  endtask

  // Per-cycle scoreboard step, called once at each negedge of a stream
  task automatic mon();
    if (i_vld && i_rdy) begin
      exp_a_q.push_back(model(ain, bin, coef, i_gs, 1'b0));
      exp_b_q.push_back(model(ain, bin, coef, i_gs, 1'b1));
    end
    if (hold_chk) begin
      chk("hold_vld", 128'(o_vld), 128'(1'b1));
      chk("hold_aout", aout, held_a);
      chk("hold_bout", bout, held_b);
    end
    if (o_vld && o_rdy) begin
      n_out++;
      if (exp_a_q.size() > 0) begin
        chk("sb_aout", aout, exp_a_q.pop_front());
        chk("sb_bout", bout, exp_b_q.pop_front());
      end else begin
        chk("sb_extra", 128'(n_out), 128'(0));
      end
    end
    hold_chk = o_vld && !o_rdy;
    held_a = aout;
    held_b = bout;
  endtask

  task automatic stream(input string tag, input int n, input int stall, input bit rnd_rdy, input bit alt_gs);
    int  sent;
    bit  fresh;
    sent = 0;
    fresh = 1'b1;
    n_out = 0;
    hold_chk = 1'b0;
    exp_a_q.delete();
    exp_b_q.delete();
    for (int cyc = 0; cyc < 4000 && sent < n; cyc++) begin
      @(posedge clk); #1;
      if (fresh) begin
        ain = rnd128(); bin = rnd128(); coef = rnd128();
        i_gs = alt_gs & sent[0];
      end
      i_vld = 1'b1;
      o_rdy = (cyc < stall) ? 1'b0 : (rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      @(negedge clk);
      mon();
      fresh = i_rdy;
      if (i_rdy) sent++;
      if (stall > 0 && cyc == stall - 1) begin
        chk("bp_accepts", 128'(sent), 128'(3));
        chk("bp_irdy", 128'(i_rdy), 128'(1'b0));
      end
    end
    @(posedge clk); #1;
    i_vld = 1'b0;
    o_rdy = 1'b1;
    for (int cyc = 0; cyc < 50 && exp_a_q.size() > 0; cyc++) begin
      @(negedge clk);
      mon();
    end
    chk({tag, "_sent"}, 128'(sent), 128'(n));
    chk({tag, "_count"}, 128'(n_out), 128'(n));
    chk({tag, "_left"}, 128'(exp_a_q.size()), 128'(0));
  endtask

  initial begin
    int stale;
    n_checks = 0;
    n_errors = 0;
    n_out = 0;
    hold_chk = 1'b0;
    held_a = 128'd0;
    held_b = 128'd0;
    rstn = 1'b0;
    ain = 128'd0; bin = 128'd0; coef = 128'd0;
    i_vld = 1'b0; i_gs = 1'b0; o_rdy = 1'b1;

    #3;
    chk("rst_ovld", 128'(o_vld), 128'(1'b0));
    chk("rst_aout", aout, 128'd0);
    chk("rst_bout", bout, 128'd0);
    chk("rst_irdy", 128'(i_rdy), 128'(1'b1));
    #19 rstn = 1'b1;

    beat("basic", 1'b0, pk(0, 0, 0, 1), pk(0, 0, 0, 2), pk(0, 0, 0, 3),
         pk(0, 0, 0, 7), pk(0, 0, 0, 8380412));
    beat("wrap", 1'b0, pk(32'h007FE000, 32'h007FE000, 32'h007FE000, 32'h007FE000),
         pk(1, 1, 1, 1), pk(1, 1, 1, 1),
         pk(0, 0, 0, 0), pk(32'h007FDFFF, 32'h007FDFFF, 32'h007FDFFF, 32'h007FDFFF));
    beat("max", 1'b0, pk(32'hFFFFE000, 32'hFFFFE000, 32'hFFFFE000, 32'hFFFFE000),
         pk(32'hFFFFE000, 32'hFFFFE000, 32'hFFFFE000, 32'hFFFFE000),
         pk(32'hFFFFE000, 32'hFFFFE000, 32'hFFFFE000, 32'hFFFFE000),
         pk(0, 0, 0, 0), pk(32'h007FDFFF, 32'h007FDFFF, 32'h007FDFFF, 32'h007FDFFF));
    beat("mixed", 1'b0, pk(8380416, 100, 0, 10), pk(0, 4194304, 8380416, 20),
         pk(12345, 4194304, 2, 30),
         pk(8380416, 6297699, 8380415, 610), pk(8380416, 2082918, 2, 8379827));

    stream("bp", 20, 10, 1'b0, 1'b0);
    stream("rnd", 250, 0, 1'b1, 1'b0);

`ifdef BPE_GS_EN
    beat("gs", 1'b1, pk(0, 0, 0, 5), pk(0, 0, 0, 2), pk(0, 0, 0, 3),
         pk(0, 0, 0, 7), pk(0, 0, 0, 9));
    stream("gsalt", 40, 0, 1'b1, 1'b1);
    i_gs = 1'b0;
`endif

    // Fill all three stages under stall, then reset asynchronously mid-cycle
    @(posedge clk); #1;
    o_rdy = 1'b0; i_vld = 1'b1;
    ain = pk(1, 2, 3, 4); bin = pk(5, 6, 7, 8); coef = pk(9, 10, 11, 12);
    repeat (3) begin
      @(posedge clk); #1;
    end
    i_vld = 1'b0;
    chk("rs_pre_ovld", 128'(o_vld), 128'(1'b1));
    #2 rstn = 1'b0;
    #1;
    chk("rs_ovld", 128'(o_vld), 128'(1'b0));
    chk("rs_aout", aout, 128'd0);
    chk("rs_bout", bout, 128'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    chk("rs_irdy", 128'(i_rdy), 128'(1'b1));
    o_rdy = 1'b1;
    stale = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (o_vld) stale++;
    end
    chk("rs_stale", 128'(stale), 128'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
